// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and defaults for the UART receive controller.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        IDLE = 2'b01,
        RECV = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-facing and consumer-facing signals of the UART receive controller.
interface uart_rx_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              rx_rdy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        input  rx_rdy, rx_data, dout_ready,
        output rx_en, dout, dout_valid
    );

    modport slave (
        output rx_rdy, rx_data, dout_ready,
        input  rx_en, dout, dout_valid
    );
endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// First-word fall-through byte FIFO; occupancy counter drives full/empty.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              w_do_wr;
    logic              w_do_rd;

    assign full    = (r_level == LW'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    // A write into a full FIFO is allowed when the head leaves in the same cycle.
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences the UART bit receiver and buffers completed bytes in a FWFT FIFO.
// Optional idle timeout flag is built when UART_RX_CTRL_TIMEOUT_EN is defined.
//
// state | meaning
// OFF   | receiver disabled, rx_en low
// IDLE  | receiver enabled, waiting for a start bit (rx_rdy low)
// RECV  | frame in progress, waiting for rx_rdy rise
// DONE  | one cycle: push rx_data into the FIFO or flag overrun
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 40
) (
    input  logic                    bclk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    ovr_clr,
    uart_rx_ctrl_if.master          bus,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overrun,
    output logic                    busy,
    output logic                    rx_timeout
);
    if (!is_pow2(DEPTH) || DEPTH < 2 || TIMEOUT_CYC < 1) begin : g_param_err
        $error("uart_rx_ctrl: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
    end

    state_t r_state;
    state_t w_state_nxt;
    logic   r_rx_rdy_q;
    logic   r_rx_en;
    logic   r_busy;
    logic   r_overrun;
    logic   w_rise;
    logic   w_in_done;
    logic   w_pop;
    logic   w_wr;
    logic   w_drop;
    logic   w_full;
    logic   w_empty;

    assign w_rise    = bus.rx_rdy & ~r_rx_rdy_q;
    assign w_in_done = (r_state == DONE);
    assign w_pop     = ~w_empty & bus.dout_ready;
    assign w_wr      = w_in_done & (~w_full | w_pop);
    assign w_drop    = w_in_done & w_full & ~w_pop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OFF:     if (enable) w_state_nxt = IDLE;
            IDLE:    if (!bus.rx_rdy) w_state_nxt = RECV;
            RECV:    if (w_rise) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = OFF;
        endcase
        if (!enable) w_state_nxt = OFF;
    end

    // rx_en and busy are registered from the next state so they track r_state exactly.
    always_ff @(posedge bclk) begin
        if (rst) begin
            r_state    <= OFF;
            r_rx_rdy_q <= 1'b1;
            r_rx_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rx_rdy_q <= bus.rx_rdy;
            r_rx_en    <= (w_state_nxt != OFF);
            r_busy     <= (w_state_nxt == RECV);
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (bclk),
        .rst     (rst),
        .wr_en   (w_wr),
        .wr_data (bus.rx_data),
        .rd_en   (w_pop),
        .rd_data (bus.dout),
        .level   (level),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign bus.rx_en      = r_rx_en;
    assign bus.dout_valid = ~w_empty;
    assign overrun        = r_overrun;
    assign busy           = r_busy;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_tmo_cnt;

    always_ff @(posedge bclk) begin
        if (rst || w_in_done || w_empty) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != TW'(TIMEOUT_CYC)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign rx_timeout = (r_tmo_cnt == TW'(TIMEOUT_CYC)) & ~w_empty;
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a bit-level receiver model feeds frames,
// expected bytes are queued on send and compared as the consumer pops them.
module tb_uart_rx_ctrl;

    logic       bclk;
    logic       rst;
    logic       enable;
    logic       ovr_clr;
    logic [2:0] level;
    logic       overrun;
    logic       busy;
    logic       rx_timeout;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl_if #(.DATA_W(8)) bus ();

    uart_rx_ctrl #(
        .DATA_W      (8),
        .DEPTH       (4),
        .TIMEOUT_CYC (40)
    ) dut (
        .bclk       (bclk),
        .rst        (rst),
        .enable     (enable),
        .ovr_clr    (ovr_clr),
        .bus        (bus),
        .level      (level),
        .overrun    (overrun),
        .busy       (busy),
        .rx_timeout (rx_timeout)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge bclk);
        #1;
    endtask

    // Start bit plus three data bits; busy must be up by then.
    task automatic start_frame();
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'($urandom);
        tick(2);
        chk("busy_mid", busy, 1'b1);
        tick(2);
    endtask

    task automatic finish_frame(input logic [7:0] b);
        bus.rx_data = 8'($urandom);
        tick(5);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit accept);
        tick(2);
        start_frame();
        finish_frame(b);
        if (accept) exp_q.push_back(b);
    endtask

    task automatic drain();
        int n = 0;
        bus.dout_ready = 1'b1;
        while (bus.dout_valid && n < 20) begin
            tick(1);
            n++;
        end
        bus.dout_ready = 1'b0;
        chk("drain_done", bus.dout_valid, 1'b0);
    endtask

    always @(negedge bclk) begin
        if (!rst && bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
            else chk("sb_data", bus.dout, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        enable         = 1'b0;
        ovr_clr        = 1'b0;
        bus.rx_rdy     = 1'b1;
        bus.rx_data    = '0;
        bus.dout_ready = 1'b0;
        tick(3);
        chk("rst_rx_en", bus.rx_en, 1'b0);
        chk("rst_valid", bus.dout_valid, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", rx_timeout, 1'b0);
        rst = 1'b0;

        // Two frames held in the FIFO, latency of two posedges after the rise
        enable = 1'b1;
        tick(2);
        chk("t1_rx_en", bus.rx_en, 1'b1);
        send_frame(8'h55, 1'b1);
        tick(1);
        chk("t1_lat1_valid", bus.dout_valid, 1'b0);
        tick(1);
        chk("t1_lat2_valid", bus.dout_valid, 1'b1);
        chk("t1_lat2_level", level, 3'd1);
        send_frame(8'hA3, 1'b1);
        tick(1);
        chk("t1_lat1_level", level, 3'd1);
        tick(1);
        chk("t1_level", level, 3'd2);
        chk("t1_head", bus.dout, 8'h55);
        chk("t1_overrun", overrun, 1'b0);
        drain();

        // Fill, overflow with a same-cycle clear (set wins), drain, clear
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        tick(2);
        chk("t2_full_level", level, 3'd4);
        chk("t2_no_ovr_yet", overrun, 1'b0);
        tick(2);
        start_frame();
        finish_frame(8'h05);
        tick(1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        chk("t2_set_wins", overrun, 1'b1);
        chk("t2_level", level, 3'd4);
        drain();
        chk("t2_sticky", overrun, 1'b1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        chk("t2_cleared", overrun, 1'b0);

        // Full FIFO with a pop in the DONE cycle: byte accepted, no overrun
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        tick(2);
        start_frame();
        finish_frame(8'h05);
        exp_q.push_back(8'h05);
        tick(1);
        bus.dout_ready = 1'b1;
        tick(1);
        bus.dout_ready = 1'b0;
        chk("t3_overrun", overrun, 1'b0);
        chk("t3_level", level, 3'd4);
        chk("t3_head", bus.dout, 8'h02);
        drain();

        // Enable dropped mid-frame: byte discarded, then normal capture
        tick(2);
        start_frame();
        enable = 1'b0;
        tick(1);
        chk("t4_rx_en", bus.rx_en, 1'b0);
        chk("t4_busy", busy, 1'b0);
        finish_frame(8'h99);
        tick(3);
        chk("t4_level", level, 3'd0);
        enable = 1'b1;
        send_frame(8'h7E, 1'b1);
        tick(2);
        chk("t4_reen_level", level, 3'd1);
        drain();

        // Reset mid-frame with two bytes buffered
        send_frame(8'h21, 1'b0);
        send_frame(8'h22, 1'b0);
        tick(2);
        chk("t5_pre_level", level, 3'd2);
        tick(2);
        start_frame();
        rst        = 1'b1;
        bus.rx_rdy = 1'b1;
        tick(1);
        chk("t5_level", level, 3'd0);
        chk("t5_valid", bus.dout_valid, 1'b0);
        chk("t5_rx_en", bus.rx_en, 1'b0);
        chk("t5_overrun", overrun, 1'b0);
        chk("t5_busy", busy, 1'b0);
        rst = 1'b0;
        tick(3);

        // Idle timeout with data pending
        send_frame(8'h10, 1'b1);
        tick(2);
`ifdef UART_RX_CTRL_TIMEOUT_EN
        tick(39);
        chk("t6_tmo_early", rx_timeout, 1'b0);
        tick(1);
        chk("t6_tmo_set", rx_timeout, 1'b1);
        send_frame(8'h11, 1'b1);
        tick(1);
        chk("t6_tmo_in_done", rx_timeout, 1'b1);
        tick(1);
        chk("t6_tmo_drop", rx_timeout, 1'b0);
`else
        tick(45);
        chk("t6_no_tmo", rx_timeout, 1'b0);
        send_frame(8'h11, 1'b1);
        tick(2);
        chk("t6_no_tmo2", rx_timeout, 1'b0);
`endif
        chk("t6_level", level, 3'd2);
        drain();
        chk("t6_tmo_empty", rx_timeout, 1'b0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the UART bit-level receiver (rxd → 8-bit dout, rx_rdy handshake).
- Gates the receiver enable.
- Detects frame completion on the rx_rdy rising edge.
- Buffers received bytes in a small FIFO with a valid/ready consumer interface.
- Flags overrun when a byte arrives while the FIFO is full.
- Sits between the receiver and the host/bus-side logic, in the bclk domain.

Parameters:
DATA_W, 8, byte width; must match the receiver dout width.
DEPTH, 4, FIFO entries; power of two, ≥2.
TIMEOUT_CYC, 40, idle bclk cycles before rx_timeout (used only with the feature macro).

Ports:
bclk  in  1  bit-rate clock; all logic on posedge.
rst  in  1  reset; synchronous, active-high.
enable  in  1  host receive enable.
rx_rdy  in  1  receiver ready/idle flag (1 = idle or frame done).
rx_data  in  DATA_W  receiver dout; stable while rx_rdy=1.
rx_en  out  1  enable to the receiver.
dout  out  DATA_W  FIFO head byte (first-word fall-through).
dout_valid  out  1  FIFO non-empty.
dout_ready  in  1  consumer pop; a pop occurs when dout_valid & dout_ready.
level  out  $clog2(DEPTH)+1  current FIFO occupancy.
overrun  out  1  sticky: a completed byte was dropped because the FIFO was full.
ovr_clr  in  1  clears overrun.
busy  out  1  a frame is in progress (state RECV).
rx_timeout  out  1  idle timeout with data pending (optional feature; otherwise 0).

Behaviour:
- Reset (rst=1 at posedge) sets the following, overriding all other inputs that cycle:
  - rx_en=0, dout_valid=0, level=0, overrun=0, busy=0, rx_timeout=0.
  - FIFO pointers cleared; state=OFF; rx_rdy_q=1.
  - dout is don't-care while dout_valid=0.
- rx_rdy_q registers rx_rdy each cycle. Rise is rx_rdy & ~rx_rdy_q.
- State machine (2-bit):
  - OFF: rx_en=0. Goes to IDLE when enable=1.
  - IDLE: rx_en=1. Goes to RECV when rx_rdy=0 (receiver took a start bit).
  - RECV: rx_en=1, busy=1. On rise, goes to DONE.
  - DONE: one cycle. Issues a write of rx_data, then returns to IDLE.
  - From any state, enable=0 forces OFF next cycle and drops rx_en the same cycle via a registered output. A byte in flight is discarded: a rise seen in OFF is ignored. FIFO contents are retained.
- Write rule in DONE:
  - Accepted if level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun is set next cycle.
- Simultaneous write and pop: level is unchanged and both pointers advance.
- Pop on empty: ignored.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally; full/empty are derived from level.
- Latency:
  - rise → DONE: 1 cycle.
  - DONE → dout_valid=1 (if FIFO was empty): 1 cycle.
  - Total: 2 posedges after rx_rdy rises.
- overrun and ovr_clr in the same cycle: set wins (sticky stays 1).
- Receiver reset (rx_rdy forced to 1) mid-frame looks like a rise. It is captured as a byte; this is accepted behaviour, and the system resets both blocks together.

Optional Feature:
Macro: UART_RX_CTRL_TIMEOUT_EN.
- Defined:
  - A counter clears on every DONE and whenever the FIFO is empty.
  - Otherwise it increments, saturating at TIMEOUT_CYC.
  - rx_timeout=1 while counter==TIMEOUT_CYC and dout_valid=1.
  - It drops the cycle after a DONE or when the FIFO empties.
- Not defined: rx_timeout is tied to 0, no counter logic exists, and TIMEOUT_CYC is unused.

Decomposition:
- Package uart_pkg:
  - State localparams OFF=2'b00, IDLE=2'b01, RECV=2'b10, DONE=2'b11.
  - Default DATA_W.
- One sub-module, uart_rx_fifo: synchronous FWFT FIFO with ports wr_en, wr_data, rd_en, rd_data, level, full, empty.
- The controller keeps the FSM, edge detect, overrun and timeout logic.

Test Plan:
1. enable=1; drive frames 0x55 then 0xA3 into the receiver model; hold dout_ready=0 → level=2, dout=0x55, overrun=0; each dout_valid/level update occurs 2 posedges after rx_rdy rises.
2. Fill 4 bytes 0x01..0x04 with dout_ready=0, then send 0x05 → level=4, overrun=1, dout sequence on drain is 0x01..0x04 only; pulse ovr_clr → overrun=0.
3. With FIFO full, assert dout_ready in the DONE cycle of byte 0x05 → no overrun, level stays 4, drained order is 0x02..0x05.
4. Drop enable mid-frame (after 3 data bits) → rx_en=0 next cycle, state OFF, completing rise is ignored, level unchanged; re-enable and send 0x7E → captured normally.
5. Assert rst mid-frame with 2 bytes buffered → next cycle level=0, dout_valid=0, rx_en=0, overrun=0, busy=0.
6. (UART_RX_CTRL_TIMEOUT_EN) receive 0x10 and hold dout_ready=0 → rx_timeout=1 after 40 idle cycles; send 0x11 → rx_timeout=0 next cycle; without macro, rx_timeout stays 0 throughout.
